// File: rtl/axis_uart_mc_pkg.sv
// Shared types and constants for the multi-channel AXI-Stream UART.
package axis_uart_mc_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  localparam int TUSER_OVR  = 2;
  localparam int TUSER_FERR = 1;
  localparam int TUSER_PERR = 0;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Clock cycles per bit, rounded to nearest.
  function automatic int calc_bit_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/axis_uart_mc_chan.sv
// One full-duplex UART channel: TX serializer, RX deserializer with
// framing/parity/break detection, and a single-entry holding register.
module axis_uart_mc_chan
  import axis_uart_mc_pkg::*;
#(
  parameter int BIT_DIV   = 16,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = PARITY_NONE,
  parameter int STOP_BITS = 1
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_idle,
  output logic                 txd,
  input  logic                 rxd,
  input  logic                 grant,
  output logic                 hold_valid,
  output logic [DATA_BITS-1:0] hold_data,
  output logic [2:0]           hold_flags,
  output logic                 break_det
);

  localparam int CNT_W = $clog2(STOP_BITS * BIT_DIV + 1);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS * BIT_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic ODD     = (PARITY == PARITY_ODD);
  localparam bit   HAS_PAR = (PARITY != PARITY_NONE);

  tx_state_t            tx_state, tx_state_nxt;
  logic [CNT_W-1:0]     tx_cnt, tx_cnt_nxt;
  logic [IDX_W-1:0]     tx_idx, tx_idx_nxt;
  logic [DATA_BITS-1:0] tx_buf, tx_buf_nxt;
  logic                 tx_par, tx_par_nxt;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_buf   <= '0;
      tx_par   <= 1'b0;
    end else begin
      tx_state <= tx_state_nxt;
      tx_cnt   <= tx_cnt_nxt;
      tx_idx   <= tx_idx_nxt;
      tx_buf   <= tx_buf_nxt;
      tx_par   <= tx_par_nxt;
    end
  end

  // The data buffer shifts right so the current bit is always tx_buf[0].
  always_comb begin
    tx_state_nxt = tx_state;
    tx_cnt_nxt   = tx_cnt + 1'b1;
    tx_idx_nxt   = tx_idx;
    tx_buf_nxt   = tx_buf;
    tx_par_nxt   = tx_par;
    unique case (tx_state)
      TX_IDLE: begin
        tx_cnt_nxt = '0;
        if (tx_start) begin
          tx_state_nxt = TX_START;
          tx_buf_nxt   = tx_data;
          tx_par_nxt   = (^tx_data) ^ ODD;
        end
      end
      TX_START: if (tx_cnt == BIT_LAST) begin
        tx_state_nxt = TX_DATA;
        tx_cnt_nxt   = '0;
        tx_idx_nxt   = '0;
      end
      TX_DATA: if (tx_cnt == BIT_LAST) begin
        tx_cnt_nxt = '0;
        tx_idx_nxt = tx_idx + 1'b1;
        tx_buf_nxt = tx_buf >> 1;
        if (tx_idx == IDX_LAST) tx_state_nxt = HAS_PAR ? TX_PARITY : TX_STOP;
      end
      TX_PARITY: if (tx_cnt == BIT_LAST) begin
        tx_state_nxt = TX_STOP;
        tx_cnt_nxt   = '0;
      end
      TX_STOP: if (tx_cnt == STOP_LAST) begin
        tx_state_nxt = TX_IDLE;
        tx_cnt_nxt   = '0;
      end
      default: tx_state_nxt = TX_IDLE;
    endcase
  end

  always_comb begin
    txd     = 1'b1;
    tx_idle = 1'b0;
    case (tx_state)
      TX_IDLE:   tx_idle = 1'b1;
      TX_START:  txd = 1'b0;
      TX_DATA:   txd = tx_buf[0];
      TX_PARITY: txd = tx_par;
      default:   txd = 1'b1;
    endcase
  end

  logic [1:0] rx_sync;
  logic       rx_s;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) rx_sync <= 2'b11;
    else          rx_sync <= {rx_sync[0], rxd};
  end

  assign rx_s = rx_sync[1];

  rx_state_t            rx_state, rx_state_nxt;
  logic [CNT_W-1:0]     rx_cnt, rx_cnt_nxt;
  logic [IDX_W-1:0]     rx_idx, rx_idx_nxt;
  logic [DATA_BITS-1:0] rx_buf, rx_buf_nxt;
  logic                 rx_par, rx_par_nxt;
  logic                 rx_stop_smp, rx_brk, rx_write, rx_perr;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_buf   <= '0;
      rx_par   <= 1'b0;
    end else begin
      rx_state <= rx_state_nxt;
      rx_cnt   <= rx_cnt_nxt;
      rx_idx   <= rx_idx_nxt;
      rx_buf   <= rx_buf_nxt;
      rx_par   <= rx_par_nxt;
    end
  end

  // IDLE is only ever entered with the line high, so a low level there is a falling edge.
  always_comb begin
    rx_state_nxt = rx_state;
    rx_cnt_nxt   = rx_cnt + 1'b1;
    rx_idx_nxt   = rx_idx;
    rx_buf_nxt   = rx_buf;
    rx_par_nxt   = rx_par;
    unique case (rx_state)
      RX_IDLE: begin
        rx_cnt_nxt = '0;
        if (!rx_s) rx_state_nxt = RX_START;
      end
      RX_START: if (rx_cnt == HALF_LAST) begin
        rx_cnt_nxt   = '0;
        rx_idx_nxt   = '0;
        rx_state_nxt = rx_s ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_cnt == BIT_LAST) begin
        rx_cnt_nxt = '0;
        rx_idx_nxt = rx_idx + 1'b1;
        rx_buf_nxt = {rx_s, rx_buf[DATA_BITS-1:1]};
        if (rx_idx == IDX_LAST) rx_state_nxt = HAS_PAR ? RX_PARITY : RX_STOP;
      end
      RX_PARITY: if (rx_cnt == BIT_LAST) begin
        rx_cnt_nxt   = '0;
        rx_par_nxt   = rx_s;
        rx_state_nxt = RX_STOP;
      end
      RX_STOP: if (rx_cnt == BIT_LAST) begin
        rx_cnt_nxt   = '0;
        rx_state_nxt = rx_s ? RX_IDLE : RX_WAIT_HIGH;
      end
      RX_WAIT_HIGH: begin
        rx_cnt_nxt = '0;
        if (rx_s) rx_state_nxt = RX_IDLE;
      end
      default: rx_state_nxt = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_stop_smp = (rx_state == RX_STOP) && (rx_cnt == BIT_LAST);
    rx_brk      = rx_stop_smp && !rx_s && (rx_buf == '0) && !(HAS_PAR && rx_par);
    rx_write    = rx_stop_smp && !rx_brk;
    rx_perr     = HAS_PAR && (rx_par != ((^rx_buf) ^ ODD));
  end

  // A grant in the write cycle drains the old character, so it is not an overrun.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
      hold_flags <= '0;
      break_det  <= 1'b0;
    end else begin
      break_det <= rx_brk;
      if (rx_write) begin
        hold_valid             <= 1'b1;
        hold_data              <= rx_buf;
        hold_flags[TUSER_OVR]  <= hold_valid && !grant;
        hold_flags[TUSER_FERR] <= !rx_s;
        hold_flags[TUSER_PERR] <= rx_perr;
      end else if (grant) begin
        hold_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/axis_uart_mc.sv
// Multi-channel AXI-Stream UART: TDEST-routed TX, round-robin merged RX
// tagged with TID.
module axis_uart_mc
  import axis_uart_mc_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int ACLK_FREQ_HZ = 100000000,
  parameter int BAUDRATE     = 115200,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  localparam int CW          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [15:0]       s_axis_tdata,
  input  logic [CW-1:0]     s_axis_tdest,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [15:0]       m_axis_tdata,
  output logic [CW-1:0]     m_axis_tid,
  output logic [2:0]        m_axis_tuser,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [NUM_CH-1:0] txd,
  input  logic [NUM_CH-1:0] rxd,
  output logic [NUM_CH-1:0] break_det
);

  localparam int BIT_DIV = calc_bit_div(ACLK_FREQ_HZ, BAUDRATE);

  if (BIT_DIV < 8 || NUM_CH < 1 || NUM_CH > 16 || DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_cfg
    $error("axis_uart_mc: unsupported configuration (BIT_DIV=%0d)", BIT_DIV);
  end

  logic [NUM_CH-1:0]    tx_idle, tx_start, hold_valid, grant;
  logic [DATA_BITS-1:0] hold_data [NUM_CH];
  logic [2:0]           hold_flags [NUM_CH];
  logic [CW-1:0]        last_grant, pick, pick_hi, pick_lo;
  logic                 pick_found, found_hi, found_lo, out_load;
  logic                 unused_tdata;

  assign unused_tdata = ^s_axis_tdata[15:DATA_BITS];

  // Beats addressed to a nonexistent channel are accepted and dropped.
  always_comb begin
    s_axis_tready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (s_axis_tdest == CW'(i)) s_axis_tready = tx_idle[i];
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign tx_start[i] = s_axis_tvalid && s_axis_tready && (s_axis_tdest == CW'(i));

    axis_uart_mc_chan #(
      .BIT_DIV   (BIT_DIV),
      .DATA_BITS (DATA_BITS),
      .PARITY    (PARITY),
      .STOP_BITS (STOP_BITS)
    ) u_chan (
      .aclk       (aclk),
      .aresetn    (aresetn),
      .tx_start   (tx_start[i]),
      .tx_data    (s_axis_tdata[DATA_BITS-1:0]),
      .tx_idle    (tx_idle[i]),
      .txd        (txd[i]),
      .rxd        (rxd[i]),
      .grant      (grant[i]),
      .hold_valid (hold_valid[i]),
      .hold_data  (hold_data[i]),
      .hold_flags (hold_flags[i]),
      .break_det  (break_det[i])
    );
  end

  // Round robin: first pending channel above last_grant, else wrap to the lowest.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    pick_hi  = '0;
    pick_lo  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (hold_valid[i] && !found_hi && (CW'(i) > last_grant)) begin
        found_hi = 1'b1;
        pick_hi  = CW'(i);
      end
      if (hold_valid[i] && !found_lo && (CW'(i) <= last_grant)) begin
        found_lo = 1'b1;
        pick_lo  = CW'(i);
      end
    end
    pick_found = found_hi || found_lo;
    pick       = found_hi ? pick_hi : pick_lo;
    out_load   = !m_axis_tvalid || m_axis_tready;
    for (int i = 0; i < NUM_CH; i++) begin
      grant[i] = out_load && pick_found && (pick == CW'(i));
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tid    <= '0;
      m_axis_tuser  <= '0;
      last_grant    <= CW'(NUM_CH - 1);
    end else if (out_load) begin
      m_axis_tvalid <= pick_found;
      if (pick_found) begin
        m_axis_tdata <= 16'(hold_data[pick]);
        m_axis_tid   <= pick;
        m_axis_tuser <= hold_flags[pick];
        last_grant   <= pick;
      end
    end
  end

endmodule

// File: tb/tb_axis_uart_mc.sv
// Directed bench for axis_uart_mc: one 8N1 instance and one 8E1 instance,
// 16 clocks per bit.
module tb_axis_uart_mc;

  localparam int NCH = 4;
  localparam int BD  = 16;

  logic        aclk = 1'b0;
  logic        aresetn;

  logic [15:0] s_axis_tdata;
  logic [1:0]  s_axis_tdest;
  logic        s_axis_tvalid, s_axis_tready;
  logic [15:0] m_axis_tdata;
  logic [1:0]  m_axis_tid;
  logic [2:0]  m_axis_tuser;
  logic        m_axis_tvalid, m_axis_tready;
  logic [3:0]  txd, rxd, break_det;

  logic [15:0] p_s_tdata;
  logic [1:0]  p_s_tdest;
  logic        p_s_tvalid, p_s_tready;
  logic [15:0] p_m_tdata;
  logic [1:0]  p_m_tid;
  logic [2:0]  p_m_tuser;
  logic        p_m_tvalid, p_m_tready;
  logic [3:0]  p_txd, p_rxd, p_break_det;

  always #5 aclk = ~aclk;

  axis_uart_mc #(
    .NUM_CH(NCH), .ACLK_FREQ_HZ(1600000), .BAUDRATE(100000),
    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tdest(s_axis_tdest),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tid(m_axis_tid), .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .txd(txd), .rxd(rxd), .break_det(break_det)
  );

  axis_uart_mc #(
    .NUM_CH(NCH), .ACLK_FREQ_HZ(1600000), .BAUDRATE(100000),
    .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)
  ) dut_p (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(p_s_tdata), .s_axis_tdest(p_s_tdest),
    .s_axis_tvalid(p_s_tvalid), .s_axis_tready(p_s_tready),
    .m_axis_tdata(p_m_tdata), .m_axis_tid(p_m_tid), .m_axis_tuser(p_m_tuser),
    .m_axis_tvalid(p_m_tvalid), .m_axis_tready(p_m_tready),
    .txd(p_txd), .rxd(p_rxd), .break_det(p_break_det)
  );

  typedef struct {
    logic [15:0] data;
    logic [1:0]  id;
    logic [2:0]  user;
    int          cyc;
  } beat_t;

  beat_t      q[$];
  beat_t      qp[$];
  beat_t      mon_b, mon_bp;
  int         cyc = 0;
  int         brk_cnt [NCH];
  int         n_checks = 0;
  int         n_fail = 0;
  logic [10:0] frm [NCH];

  always @(posedge aclk) cyc <= cyc + 1;

  // Transfers are recorded mid-cycle, before the edge that completes them.
  always @(negedge aclk) begin
    if (aresetn && m_axis_tvalid && m_axis_tready) begin
      mon_b.data = m_axis_tdata; mon_b.id = m_axis_tid; mon_b.user = m_axis_tuser; mon_b.cyc = cyc;
      q.push_back(mon_b);
    end
    if (aresetn && p_m_tvalid && p_m_tready) begin
      mon_bp.data = p_m_tdata; mon_bp.id = p_m_tid; mon_bp.user = p_m_tuser; mon_bp.cyc = cyc;
      qp.push_back(mon_bp);
    end
    for (int i = 0; i < NCH; i++) if (break_det[i]) brk_cnt[i]++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] d, input bit par, input bit flip);
    logic [10:0] f;
    f = '1;
    f[0] = 1'b0;
    f[8:1] = d;
    if (par) f[9] = (^d) ^ flip;
    return f;
  endfunction

  task automatic send_lines(input logic [3:0] mask, input int nbits, input bit on_p);
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < NCH; c++) begin
        if (mask[c]) begin
          if (on_p) p_rxd[c] = frm[c][b];
          else      rxd[c]   = frm[c][b];
        end
      end
      tick(BD);
    end
  endtask

  task automatic test_reset;
    tick(3);
    n_checks++; if (txd !== 4'hF) begin n_fail++; $display("[TB] FAIL reset_txd: got %h expected %h", txd, 4'hF); end
    n_checks++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_tvalid: got %b expected 0", m_axis_tvalid); end
    n_checks++; if ({m_axis_tdata, m_axis_tid, m_axis_tuser} !== 21'h0) begin n_fail++; $display("[TB] FAIL reset_tdata_tid_tuser: got %h/%h/%h expected 0", m_axis_tdata, m_axis_tid, m_axis_tuser); end
    n_checks++; if (break_det !== 4'h0) begin n_fail++; $display("[TB] FAIL reset_break_det: got %h expected 0", break_det); end
    aresetn = 1'b1;
    tick(2);
    n_checks++; if (s_axis_tready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_tready: got %b expected 1", s_axis_tready); end
    n_checks++; if (p_txd !== 4'hF) begin n_fail++; $display("[TB] FAIL reset_p_txd: got %h expected %h", p_txd, 4'hF); end
  endtask

  task automatic test_tx;
    logic [7:0] pat;
    logic       exp_bit;
    int         b;
    pat = 8'hA5;
    s_axis_tdata = 16'h7EA5; s_axis_tdest = 2'd2; s_axis_tvalid = 1'b1;
    #1;
    n_checks++; if (s_axis_tready !== 1'b1) begin n_fail++; $display("[TB] FAIL tx_accept_ready: got %b expected 1", s_axis_tready); end
    tick(1);
    s_axis_tvalid = 1'b0;
    for (int c = 1; c <= 161; c++) begin
      b = (c - 1) / BD;
      if (c == 161)   exp_bit = 1'b1;
      else if (b == 0) exp_bit = 1'b0;
      else if (b <= 8) exp_bit = pat[b-1];
      else            exp_bit = 1'b1;
      n_checks++; if (txd[2] !== exp_bit) begin n_fail++; $display("[TB] FAIL tx_txd2 cycle %0d: got %b expected %b", c, txd[2], exp_bit); end
      n_checks++; if (s_axis_tready !== (c == 161)) begin n_fail++; $display("[TB] FAIL tx_tready cycle %0d: got %b expected %b", c, s_axis_tready, (c == 161)); end
      n_checks++; if ({txd[3], txd[1:0]} !== 3'b111) begin n_fail++; $display("[TB] FAIL tx_other_lines cycle %0d: got %h expected 7", c, {txd[3], txd[1:0]}); end
      tick(1);
    end
  endtask

  task automatic test_rx_parity;
    p_m_tready = 1'b1;
    qp.delete();
    frm[1] = make_frame(8'h3C, 1'b1, 1'b0);
    send_lines(4'b0010, 11, 1'b1);
    tick(30);
    n_checks++; if (qp.size() !== 1) begin n_fail++; $display("[TB] FAIL rxpar_good_count: got %0d expected 1", qp.size()); end
    if (qp.size() > 0) begin
      n_checks++; if (qp[0].data !== 16'h003C) begin n_fail++; $display("[TB] FAIL rxpar_good_data: got %h expected 003c", qp[0].data); end
      n_checks++; if (qp[0].id !== 2'd1) begin n_fail++; $display("[TB] FAIL rxpar_good_tid: got %0d expected 1", qp[0].id); end
      n_checks++; if (qp[0].user !== 3'b000) begin n_fail++; $display("[TB] FAIL rxpar_good_tuser: got %b expected 000", qp[0].user); end
    end
    qp.delete();
    frm[1] = make_frame(8'h3C, 1'b1, 1'b1);
    send_lines(4'b0010, 11, 1'b1);
    tick(30);
    n_checks++; if (qp.size() !== 1) begin n_fail++; $display("[TB] FAIL rxpar_bad_count: got %0d expected 1", qp.size()); end
    if (qp.size() > 0) begin
      n_checks++; if (qp[0].data !== 16'h003C) begin n_fail++; $display("[TB] FAIL rxpar_bad_data: got %h expected 003c", qp[0].data); end
      n_checks++; if (qp[0].user !== 3'b001) begin n_fail++; $display("[TB] FAIL rxpar_bad_tuser: got %b expected 001", qp[0].user); end
    end
  endtask

  task automatic test_simultaneous(input logic [7:0] d0, input logic [7:0] d3);
    m_axis_tready = 1'b1;
    q.delete();
    frm[0] = make_frame(d0, 1'b0, 1'b0);
    frm[3] = make_frame(d3, 1'b0, 1'b0);
    send_lines(4'b1001, 10, 1'b0);
    tick(30);
    n_checks++; if (q.size() !== 2) begin n_fail++; $display("[TB] FAIL sim_count: got %0d expected 2", q.size()); end
    if (q.size() >= 2) begin
      n_checks++; if ({q[0].id, q[0].data} !== {2'd0, 8'h00, d0}) begin n_fail++; $display("[TB] FAIL sim_first: got id %0d data %h expected id 0 data %h", q[0].id, q[0].data, d0); end
      n_checks++; if ({q[1].id, q[1].data} !== {2'd3, 8'h00, d3}) begin n_fail++; $display("[TB] FAIL sim_second: got id %0d data %h expected id 3 data %h", q[1].id, q[1].data, d3); end
      n_checks++; if (q[1].cyc - q[0].cyc !== 1) begin n_fail++; $display("[TB] FAIL sim_spacing: got %0d cycles expected 1", q[1].cyc - q[0].cyc); end
      n_checks++; if ({q[0].user, q[1].user} !== 6'b0) begin n_fail++; $display("[TB] FAIL sim_tuser: got %b/%b expected 000/000", q[0].user, q[1].user); end
    end
  endtask

  task automatic test_overrun;
    m_axis_tready = 1'b0;
    q.delete();
    frm[1] = make_frame(8'h11, 1'b0, 1'b0);
    send_lines(4'b0010, 10, 1'b0);
    tick(20);
    n_checks++; if ({m_axis_tvalid, m_axis_tid, m_axis_tdata} !== {1'b1, 2'd1, 16'h0011}) begin n_fail++; $display("[TB] FAIL ovr_first_held: got v%b id%0d %h expected v1 id1 0011", m_axis_tvalid, m_axis_tid, m_axis_tdata); end
    frm[1] = make_frame(8'h22, 1'b0, 1'b0);
    send_lines(4'b0010, 10, 1'b0);
    frm[1] = make_frame(8'h33, 1'b0, 1'b0);
    send_lines(4'b0010, 10, 1'b0);
    tick(20);
    n_checks++; if ({m_axis_tvalid, m_axis_tdata, m_axis_tuser} !== {1'b1, 16'h0011, 3'b000}) begin n_fail++; $display("[TB] FAIL ovr_still_held: got v%b %h %b expected v1 0011 000", m_axis_tvalid, m_axis_tdata, m_axis_tuser); end
    m_axis_tready = 1'b1;
    tick(5);
    n_checks++; if (q.size() !== 2) begin n_fail++; $display("[TB] FAIL ovr_count: got %0d expected 2", q.size()); end
    if (q.size() >= 2) begin
      n_checks++; if ({q[0].data, q[0].user} !== {16'h0011, 3'b000}) begin n_fail++; $display("[TB] FAIL ovr_beat0: got %h %b expected 0011 000", q[0].data, q[0].user); end
      n_checks++; if ({q[1].data, q[1].user} !== {16'h0033, 3'b100}) begin n_fail++; $display("[TB] FAIL ovr_beat1: got %h %b expected 0033 100", q[1].data, q[1].user); end
    end
    n_checks++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL ovr_drained: got %b expected 0", m_axis_tvalid); end
  endtask

  task automatic test_break;
    m_axis_tready = 1'b1;
    q.delete();
    for (int i = 0; i < NCH; i++) brk_cnt[i] = 0;
    rxd[0] = 1'b0;
    tick(20 * BD);
    rxd[0] = 1'b1;
    tick(40);
    n_checks++; if (brk_cnt[0] !== 1) begin n_fail++; $display("[TB] FAIL brk_pulses: got %0d expected 1", brk_cnt[0]); end
    n_checks++; if (q.size() !== 0) begin n_fail++; $display("[TB] FAIL brk_no_beat: got %0d beats expected 0", q.size()); end
    frm[0] = make_frame(8'h55, 1'b0, 1'b0);
    send_lines(4'b0001, 10, 1'b0);
    tick(30);
    n_checks++; if (q.size() !== 1) begin n_fail++; $display("[TB] FAIL brk_recover_count: got %0d expected 1", q.size()); end
    if (q.size() > 0) begin
      n_checks++; if ({q[0].id, q[0].data, q[0].user} !== {2'd0, 16'h0055, 3'b000}) begin n_fail++; $display("[TB] FAIL brk_recover_beat: got id%0d %h %b expected id0 0055 000", q[0].id, q[0].data, q[0].user); end
    end
  endtask

  task automatic test_glitch;
    q.delete();
    for (int i = 0; i < NCH; i++) brk_cnt[i] = 0;
    rxd[2] = 1'b0;
    tick(4);
    rxd[2] = 1'b1;
    tick(200);
    n_checks++; if (q.size() !== 0) begin n_fail++; $display("[TB] FAIL glitch_no_beat: got %0d beats expected 0", q.size()); end
    n_checks++; if (brk_cnt[2] !== 0) begin n_fail++; $display("[TB] FAIL glitch_no_break: got %0d expected 0", brk_cnt[2]); end
  endtask

  task automatic test_reset_mid_frame;
    m_axis_tready = 1'b0;
    frm[2] = make_frame(8'h5A, 1'b0, 1'b0);
    send_lines(4'b0100, 10, 1'b0);
    tick(20);
    n_checks++; if (m_axis_tvalid !== 1'b1) begin n_fail++; $display("[TB] FAIL rstmid_pre_tvalid: got %b expected 1", m_axis_tvalid); end
    s_axis_tdata = 16'h0000; s_axis_tdest = 2'd1; s_axis_tvalid = 1'b1;
    tick(1);
    s_axis_tvalid = 1'b0;
    tick(40);
    n_checks++; if (txd[1] !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_pre_txd1: got %b expected 0", txd[1]); end
    #2;
    aresetn = 1'b0;
    #1;
    n_checks++; if (txd !== 4'hF) begin n_fail++; $display("[TB] FAIL rstmid_txd: got %h expected f", txd); end
    n_checks++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_tvalid: got %b expected 0", m_axis_tvalid); end
    tick(2);
    aresetn = 1'b1;
    tick(3);
    n_checks++; if ({s_axis_tready, txd} !== 5'h1F) begin n_fail++; $display("[TB] FAIL rstmid_after: got ready %b txd %h expected 1 f", s_axis_tready, txd); end
  endtask

  initial begin
    aresetn = 1'b0;
    s_axis_tdata = '0; s_axis_tdest = '0; s_axis_tvalid = 1'b0; m_axis_tready = 1'b1;
    p_s_tdata = '0; p_s_tdest = '0; p_s_tvalid = 1'b0; p_m_tready = 1'b1;
    rxd = 4'hF; p_rxd = 4'hF;
    for (int i = 0; i < NCH; i++) begin brk_cnt[i] = 0; frm[i] = '1; end
    $display("[TB] starting axis_uart_mc directed tests");
    test_reset();
    test_tx();
    test_rx_parity();
    test_simultaneous(8'h12, 8'h34);
    test_simultaneous(8'h56, 8'h78);
    test_overrun();
    test_break();
    test_glitch();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
